// File: rtl/sb_mac16_if.sv
// sb_mac16_if: operand, control and result bundle of the sb_mac16 DSP slice.
// The master side drives operands/controls, the slave side (the slice) returns O/CO.
interface sb_mac16_if;
  logic        CE;
  logic        IRSTTOP;
  logic        IRSTBOT;
  logic        ORSTTOP;
  logic        ORSTBOT;
  logic [15:0] A;
  logic [15:0] B;
  logic [15:0] C;
  logic [15:0] D;
  logic        AHOLD;
  logic        BHOLD;
  logic        CHOLD;
  logic        DHOLD;
  logic        OHOLDTOP;
  logic        OHOLDBOT;
  logic        OLOADTOP;
  logic        OLOADBOT;
  logic        ADDSUBTOP;
  logic        ADDSUBBOT;
  logic        CI;
  logic        CO;
  logic [31:0] O;

  modport master (
    output CE, IRSTTOP, IRSTBOT, ORSTTOP, ORSTBOT, A, B, C, D,
           AHOLD, BHOLD, CHOLD, DHOLD, OHOLDTOP, OHOLDBOT, OLOADTOP, OLOADBOT,
           ADDSUBTOP, ADDSUBBOT, CI,
    input  CO, O
  );

  modport slave (
    input  CE, IRSTTOP, IRSTBOT, ORSTTOP, ORSTBOT, A, B, C, D,
           AHOLD, BHOLD, CHOLD, DHOLD, OHOLDTOP, OHOLDBOT, OLOADTOP, OLOADBOT,
           ADDSUBTOP, ADDSUBBOT, CI,
    output CO, O
  );
endinterface

// File: rtl/sb_mac16.sv
// sb_mac16: 16x16 multiply-accumulate / 32-bit add-subtract slice.
// Optional input registers, a 16x16 multiplier built from four 8x8 partial
// products, cascaded top/bottom 16-bit adder-accumulators and per-half output muxes.
// Build option: define SB_MAC16_MODE8X8_EN to honour MODE_8x8 (H = {F, J});
// without it H is always the full 16x16 product.
module sb_mac16 #(
  parameter bit       A_REG                    = 1'b0,
  parameter bit       B_REG                    = 1'b0,
  parameter bit       C_REG                    = 1'b0,
  parameter bit       D_REG                    = 1'b0,
  parameter bit       PIPELINE_16x16_MULT_REG1 = 1'b0,
  parameter bit       PIPELINE_16x16_MULT_REG2 = 1'b0,
  parameter bit       TOP_8x8_MULT_REG         = 1'b0,
  parameter bit       BOT_8x8_MULT_REG         = 1'b0,
  parameter bit       A_SIGNED                 = 1'b0,
  parameter bit       B_SIGNED                 = 1'b0,
  parameter bit       MODE_8x8                 = 1'b0,
  parameter bit       TOPADDSUB_UPPERINPUT     = 1'b0,
  parameter bit       BOTADDSUB_UPPERINPUT     = 1'b0,
  parameter bit [1:0] TOPADDSUB_LOWERINPUT     = 2'd0,
  parameter bit [1:0] BOTADDSUB_LOWERINPUT     = 2'd0,
  parameter bit [1:0] TOPADDSUB_CARRYSELECT    = 2'd0,
  parameter bit [1:0] BOTADDSUB_CARRYSELECT    = 2'd0,
  parameter bit [1:0] TOPOUTPUT_SELECT         = 2'd0,
  parameter bit [1:0] BOTOUTPUT_SELECT         = 2'd0
) (
  input  logic      clk,
  input  logic      rst,
  sb_mac16_if.slave bus
);

  // Top half registers (A/C/F side) and bottom half (B/D/J side) have separate resets.
  logic topRst, botRst, qTopRst, qBotRst;
  assign topRst  = rst | bus.IRSTTOP;
  assign botRst  = rst | bus.IRSTBOT;
  assign qTopRst = rst | bus.ORSTTOP;
  assign qBotRst = rst | bus.ORSTBOT;

  logic [15:0] aReg, bReg, cReg, dReg;
  logic [15:0] ai, bi, ci, di;

  // Input registers: reset, then clock enable, then per-input hold.
  always_ff @(posedge clk) begin
    if (topRst) aReg <= '0; else if (bus.CE && !bus.AHOLD) aReg <= bus.A;
    if (botRst) bReg <= '0; else if (bus.CE && !bus.BHOLD) bReg <= bus.B;
    if (topRst) cReg <= '0; else if (bus.CE && !bus.CHOLD) cReg <= bus.C;
    if (botRst) dReg <= '0; else if (bus.CE && !bus.DHOLD) dReg <= bus.D;
  end

  assign ai = A_REG ? aReg : bus.A;
  assign bi = B_REG ? bReg : bus.B;
  assign ci = C_REG ? cReg : bus.C;
  assign di = D_REG ? dReg : bus.D;

  // Byte operands extended to 16 bits; only the upper bytes may carry a sign.
  // The low 16 bits of a product of extended bytes are the exact 8x8 result.
  logic [15:0] aHi, aLo, bHi, bLo;
  assign aHi = A_SIGNED ? {{8{ai[15]}}, ai[15:8]} : {8'h00, ai[15:8]};
  assign bHi = B_SIGNED ? {{8{bi[15]}}, bi[15:8]} : {8'h00, bi[15:8]};
  assign aLo = {8'h00, ai[7:0]};
  assign bLo = {8'h00, bi[7:0]};

  logic [15:0] fMul, jMul, kMul, gMul;
  assign fMul = aHi * bHi;
  assign jMul = aLo * bLo;
  assign kMul = aHi * bLo;
  assign gMul = aLo * bHi;

  logic [15:0] fPipe, kPipe, jPipe, gPipe, fReg, jReg;

  // Partial-product pipeline and the separately selectable F/J registers.
  always_ff @(posedge clk) begin
    if (topRst) begin
      fPipe <= '0;
      kPipe <= '0;
      fReg  <= '0;
    end else if (bus.CE) begin
      fPipe <= fMul;
      kPipe <= kMul;
      fReg  <= fMul;
    end
    if (botRst) begin
      jPipe <= '0;
      gPipe <= '0;
      jReg  <= '0;
    end else if (bus.CE) begin
      jPipe <= jMul;
      gPipe <= gMul;
      jReg  <= jMul;
    end
  end

  logic [15:0] f1, k1, j1, g1, fOut, jOut;
  assign f1   = PIPELINE_16x16_MULT_REG1 ? fPipe : fMul;
  assign k1   = PIPELINE_16x16_MULT_REG1 ? kPipe : kMul;
  assign j1   = PIPELINE_16x16_MULT_REG1 ? jPipe : jMul;
  assign g1   = PIPELINE_16x16_MULT_REG1 ? gPipe : gMul;
  assign fOut = TOP_8x8_MULT_REG ? fReg : fMul;
  assign jOut = BOT_8x8_MULT_REG ? jReg : jMul;

  // Cross terms are signed whenever their upper-byte operand is, so they must be
  // sign-extended before the shift into the 32-bit sum.
  logic [31:0] kExt, gExt, midSum, hFull, hComb;
  assign kExt   = A_SIGNED ? {{16{k1[15]}}, k1} : {16'h0000, k1};
  assign gExt   = B_SIGNED ? {{16{g1[15]}}, g1} : {16'h0000, g1};
  assign midSum = kExt + gExt;
  assign hFull  = {f1, 16'h0000} + {midSum[23:0], 8'h00} + {16'h0000, j1};

`ifdef SB_MAC16_MODE8X8_EN
  assign hComb = MODE_8x8 ? {f1, j1} : hFull;
`else
  // Split-multiplier mode is not built; the parameter is accepted but has no effect.
  logic unusedMode8x8;
  assign unusedMode8x8 = MODE_8x8;
  assign hComb = hFull;
`endif

  logic [31:0] hReg, hOut;

  // Product register, split so each half follows its own side's reset.
  always_ff @(posedge clk) begin
    if (topRst) hReg[31:16] <= '0; else if (bus.CE) hReg[31:16] <= hComb[31:16];
    if (botRst) hReg[15:0]  <= '0; else if (bus.CE) hReg[15:0]  <= hComb[15:0];
  end

  assign hOut = PIPELINE_16x16_MULT_REG2 ? hReg : hComb;

  logic [15:0] qTop, qBot, xTop, xBot, yTop, yBot, zTop, zBot;
  logic        cinTop, cinBot, coBot, coTop;
  logic [16:0] botSum, topSum;

  // Bottom adder operand/carry selection; a subtract treats cin as a borrow.
  always_comb begin
    xBot = BOTADDSUB_UPPERINPUT ? di : qBot;
    case (BOTADDSUB_LOWERINPUT)
      2'd0:    yBot = bi;
      2'd1:    yBot = jOut;
      2'd2:    yBot = hOut[15:0];
      default: yBot = 16'h0000;
    endcase
    case (BOTADDSUB_CARRYSELECT)
      2'd0:    cinBot = 1'b0;
      2'd1:    cinBot = 1'b1;
      default: cinBot = bus.CI;
    endcase
    if (bus.ADDSUBBOT) botSum = {1'b0, xBot} - {1'b0, yBot} - {16'h0000, cinBot};
    else               botSum = {1'b0, xBot} + {1'b0, yBot} + {16'h0000, cinBot};
  end

  assign zBot  = botSum[15:0];
  assign coBot = botSum[16];

  // Top adder; chained carry comes from the bottom adder's carry/borrow out.
  always_comb begin
    xTop = TOPADDSUB_UPPERINPUT ? ci : qTop;
    case (TOPADDSUB_LOWERINPUT)
      2'd0:    yTop = ai;
      2'd1:    yTop = fOut;
      2'd2:    yTop = hOut[31:16];
      default: yTop = {16{zBot[15]}};
    endcase
    case (TOPADDSUB_CARRYSELECT)
      2'd0:    cinTop = 1'b0;
      2'd1:    cinTop = 1'b1;
      default: cinTop = coBot;
    endcase
    if (bus.ADDSUBTOP) topSum = {1'b0, xTop} - {1'b0, yTop} - {16'h0000, cinTop};
    else               topSum = {1'b0, xTop} + {1'b0, yTop} + {16'h0000, cinTop};
  end

  assign zTop  = topSum[15:0];
  assign coTop = topSum[16];

  // Accumulators: reset, then enable, then hold, then load C/D, else take the adder sum.
  always_ff @(posedge clk) begin
    if (qTopRst)                      qTop <= '0;
    else if (bus.CE && !bus.OHOLDTOP) qTop <= bus.OLOADTOP ? ci : zTop;
    if (qBotRst)                      qBot <= '0;
    else if (bus.CE && !bus.OHOLDBOT) qBot <= bus.OLOADBOT ? di : zBot;
  end

  logic [15:0] oTop, oBot;

  // Per-half output selection.
  always_comb begin
    case (TOPOUTPUT_SELECT)
      2'd0:    oTop = zTop;
      2'd1:    oTop = qTop;
      2'd2:    oTop = fOut;
      default: oTop = hOut[31:16];
    endcase
    case (BOTOUTPUT_SELECT)
      2'd0:    oBot = zBot;
      2'd1:    oBot = qBot;
      2'd2:    oBot = jOut;
      default: oBot = hOut[15:0];
    endcase
  end

  assign bus.O  = {oTop, oBot};
  assign bus.CO = coTop;

endmodule

// File: tb/tb_sb_mac16.sv
// tb_sb_mac16: directed checks of sb_mac16 in six configurations:
// 0 adder, 1 unsigned multiply-add, 2 signed multiply-add, 3 accumulator,
// 4 split-multiplier request, 5 fully pipelined multiply-add.
module tb_sb_mac16;
  localparam int N = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ce = 1'b1;
  logic oholdBot = 1'b0;
  logic oloadBot = 1'b0;
  logic orstBot = 1'b0;
  logic [15:0] aIn [N];
  logic [15:0] bIn [N];
  logic [15:0] cIn [N];
  logic [15:0] dIn [N];
  logic        addSub [N];
  logic [31:0] oOut [N];
  logic        coOut [N];

  int nChecks = 0;
  int nFail = 0;

  always #5 clk = ~clk;

  sb_mac16_if busIf[N] ();

  for (genvar gi = 0; gi < N; gi++) begin : g_drive
    assign busIf[gi].CE        = ce;
    assign busIf[gi].IRSTTOP   = 1'b0;
    assign busIf[gi].IRSTBOT   = 1'b0;
    assign busIf[gi].ORSTTOP   = 1'b0;
    assign busIf[gi].ORSTBOT   = orstBot;
    assign busIf[gi].A         = aIn[gi];
    assign busIf[gi].B         = bIn[gi];
    assign busIf[gi].C         = cIn[gi];
    assign busIf[gi].D         = dIn[gi];
    assign busIf[gi].AHOLD     = 1'b0;
    assign busIf[gi].BHOLD     = 1'b0;
    assign busIf[gi].CHOLD     = 1'b0;
    assign busIf[gi].DHOLD     = 1'b0;
    assign busIf[gi].OHOLDTOP  = 1'b0;
    assign busIf[gi].OHOLDBOT  = oholdBot;
    assign busIf[gi].OLOADTOP  = 1'b0;
    assign busIf[gi].OLOADBOT  = oloadBot;
    assign busIf[gi].ADDSUBTOP = addSub[gi];
    assign busIf[gi].ADDSUBBOT = addSub[gi];
    assign busIf[gi].CI        = 1'b0;
    assign oOut[gi]            = busIf[gi].O;
    assign coOut[gi]           = busIf[gi].CO;
  end

  sb_mac16 #(
    .TOPADDSUB_UPPERINPUT(1'b1), .BOTADDSUB_UPPERINPUT(1'b1),
    .TOPADDSUB_CARRYSELECT(2'd2), .BOTADDSUB_CARRYSELECT(2'd2)
  ) uAdd (.clk(clk), .rst(rst), .bus(busIf[0]));

  sb_mac16 #(
    .TOPADDSUB_UPPERINPUT(1'b1), .BOTADDSUB_UPPERINPUT(1'b1),
    .TOPADDSUB_LOWERINPUT(2'd2), .BOTADDSUB_LOWERINPUT(2'd2),
    .TOPADDSUB_CARRYSELECT(2'd2), .BOTADDSUB_CARRYSELECT(2'd0)
  ) uMul (.clk(clk), .rst(rst), .bus(busIf[1]));

  sb_mac16 #(
    .A_SIGNED(1'b1), .B_SIGNED(1'b1),
    .TOPADDSUB_UPPERINPUT(1'b1), .BOTADDSUB_UPPERINPUT(1'b1),
    .TOPADDSUB_LOWERINPUT(2'd2), .BOTADDSUB_LOWERINPUT(2'd2),
    .TOPADDSUB_CARRYSELECT(2'd2), .BOTADDSUB_CARRYSELECT(2'd0)
  ) uMulS (.clk(clk), .rst(rst), .bus(busIf[2]));

  sb_mac16 #(
    .TOPOUTPUT_SELECT(2'd1), .BOTOUTPUT_SELECT(2'd1)
  ) uAcc (.clk(clk), .rst(rst), .bus(busIf[3]));

  sb_mac16 #(
    .MODE_8x8(1'b1),
    .TOPADDSUB_UPPERINPUT(1'b1), .BOTADDSUB_UPPERINPUT(1'b1),
    .TOPADDSUB_LOWERINPUT(2'd2), .BOTADDSUB_LOWERINPUT(2'd2),
    .TOPADDSUB_CARRYSELECT(2'd2), .BOTADDSUB_CARRYSELECT(2'd0)
  ) uM8 (.clk(clk), .rst(rst), .bus(busIf[4]));

  sb_mac16 #(
    .A_REG(1'b1), .B_REG(1'b1), .C_REG(1'b1), .D_REG(1'b1),
    .PIPELINE_16x16_MULT_REG1(1'b1), .PIPELINE_16x16_MULT_REG2(1'b1),
    .TOPADDSUB_UPPERINPUT(1'b1), .BOTADDSUB_UPPERINPUT(1'b1),
    .TOPADDSUB_LOWERINPUT(2'd2), .BOTADDSUB_LOWERINPUT(2'd2),
    .TOPADDSUB_CARRYSELECT(2'd2), .BOTADDSUB_CARRYSELECT(2'd0)
  ) uPipe (.clk(clk), .rst(rst), .bus(busIf[5]));

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  task automatic setOps(input int idx, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] c, input logic [15:0] d);
    aIn[idx] = a;
    bIn[idx] = b;
    cIn[idx] = c;
    dIn[idx] = d;
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      setOps(i, 16'h0, 16'h0, 16'h0, 16'h0);
      addSub[i] = 1'b0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkEq("acc_reset", oOut[3], 32'h0000_0000);
    checkEq("pipe_reset", oOut[5], 32'h0000_0000);
    rst = 1'b0;

    // Combinational 32-bit add / subtract.
    setOps(0, 16'h0000, 16'h0001, 16'h0001, 16'hFFFF);
    #1;
    checkEq("add_carry_O", oOut[0], 32'h0002_0000);
    checkEq("add_carry_CO", 32'(coOut[0]), 32'h0);
    setOps(0, 16'h0000, 16'h0001, 16'hFFFF, 16'hFFFF);
    #1;
    checkEq("add_wrap_O", oOut[0], 32'h0000_0000);
    checkEq("add_wrap_CO", 32'(coOut[0]), 32'h1);
    addSub[0] = 1'b1;
    setOps(0, 16'h0000, 16'h0007, 16'h0000, 16'h0005);
    #1;
    checkEq("sub_borrow_O", oOut[0], 32'hFFFF_FFFE);
    checkEq("sub_borrow_CO", 32'(coOut[0]), 32'h1);

    // Multiply-add, unsigned and signed.
    @(negedge clk);
    setOps(1, 16'h1234, 16'h0100, 16'h0000, 16'h0001);
    #1;
    checkEq("madd_basic", oOut[1], 32'h0012_3401);
    setOps(1, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000);
    setOps(2, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000);
    #1;
    checkEq("mul_unsigned", oOut[1], 32'hFFFE_0001);
    checkEq("mul_signed", oOut[2], 32'h0000_0001);
    setOps(2, 16'hFFFE, 16'h0003, 16'h0000, 16'h0000);
    #1;
    checkEq("mul_signed_neg", oOut[2], 32'hFFFF_FFFA);

    // Split multiplier request: honoured only in the SB_MAC16_MODE8X8_EN build.
    setOps(4, 16'h0302, 16'h0405, 16'h0000, 16'h0000);
    #1;
`ifdef SB_MAC16_MODE8X8_EN
    checkEq("mode8x8", oOut[4], 32'h000C_000A);
`else
    checkEq("mode8x8", oOut[4], 32'h000C_170A);
`endif

    // Pipelined: input reg + MULT_REG1 + MULT_REG2 gives a three-edge product latency,
    // while D only passes through its input register.
    @(negedge clk);
    setOps(5, 16'h1234, 16'h0100, 16'h0000, 16'h0001);
    repeat (2) @(negedge clk);
    checkEq("pipe_edge2", oOut[5], 32'h0000_0001);
    @(negedge clk);
    checkEq("pipe_edge3", oOut[5], 32'h0012_3401);

    // Bottom accumulator with B = 5.
    bIn[3] = 16'h0005;
    @(negedge clk);
    checkEq("acc_1", oOut[3], 32'h0000_0005);
    @(negedge clk);
    checkEq("acc_2", oOut[3], 32'h0000_000A);
    @(negedge clk);
    checkEq("acc_3", oOut[3], 32'h0000_000F);
    oholdBot = 1'b1;
    @(negedge clk);
    checkEq("acc_hold", oOut[3], 32'h0000_000F);
    oholdBot = 1'b0;
    ce = 1'b0;
    @(negedge clk);
    checkEq("acc_ce_off", oOut[3], 32'h0000_000F);
    ce = 1'b1;
    oloadBot = 1'b1;
    dIn[3] = 16'h00AA;
    @(negedge clk);
    checkEq("acc_load", oOut[3], 32'h0000_00AA);
    oloadBot = 1'b0;
    @(negedge clk);
    checkEq("acc_after_load", oOut[3], 32'h0000_00AF);
    rst = 1'b1;
    #1;
    checkEq("acc_rst_before_edge", oOut[3], 32'h0000_00AF);
    @(negedge clk);
    checkEq("acc_rst", oOut[3], 32'h0000_0000);
    rst = 1'b0;
    @(negedge clk);
    checkEq("acc_restart", oOut[3], 32'h0000_0005);
    orstBot = 1'b1;
    @(negedge clk);
    checkEq("acc_orst", oOut[3], 32'h0000_0000);
    orstBot = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end
endmodule
